// File: rtl/control_sequencer.sv
// Microcode sequencer: six-phase one-hot T-state ring plus HALT, decoding the
// IR opcode nibble into the per-phase bus strobes for the 8-bit datapath.
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_oe,
  output logic       pc_ld,
  output logic       mar_ie,
  output logic       ram_oe,
  output logic       ir_ie,
  output logic       ir_oe,
  output logic       a_ie,
  output logic       a_oe,
  output logic       b_ie,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_ie,
  output logic       halted,
  output logic [5:0] t_state
);

  typedef enum logic [6:0] {
    T1   = 7'b0000001,
    T2   = 7'b0000010,
    T3   = 7'b0000100,
    T4   = 7'b0001000,
    T5   = 7'b0010000,
    T6   = 7'b0100000,
    HALT = 7'b1000000
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e     state_q, state_d;
  logic [6:0] state_bits;

  always_comb begin
    state_d = state_q;
    case (state_q)
      T1:      state_d = run ? T2 : T1;
      T2:      state_d = T3;
      T3:      state_d = T4;
      T4:      state_d = (opcode == OP_HLT) ? HALT : T5;
      T5:      state_d = T6;
      T6:      state_d = T1;
      HALT:    state_d = HALT;
      default: state_d = T1;
    endcase
    if (rst) state_d = T1;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Strobes are combinational so they settle half a cycle before the
  // datapath's negedge capture; rst and a paused T1 force them all low.
  always_comb begin
    pc_inc  = 1'b0;
    pc_oe   = 1'b0;
    pc_ld   = 1'b0;
    mar_ie  = 1'b0;
    ram_oe  = 1'b0;
    ir_ie   = 1'b0;
    ir_oe   = 1'b0;
    a_ie    = 1'b0;
    a_oe    = 1'b0;
    b_ie    = 1'b0;
    alu_oe  = 1'b0;
    alu_sub = 1'b0;
    out_ie  = 1'b0;
    if (!rst) begin
      case (state_q)
        T1: if (run) begin
          pc_oe  = 1'b1;
          mar_ie = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_oe = 1'b1;
          ir_ie  = 1'b1;
        end
        T4: case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_oe  = 1'b1;
            mar_ie = 1'b1;
          end
          OP_JMP: begin
            ir_oe = 1'b1;
            pc_ld = 1'b1;
          end
          OP_OUT: begin
            a_oe   = 1'b1;
            out_ie = 1'b1;
          end
          default: ;
        endcase
        T5: case (opcode)
          OP_LDA: begin
            ram_oe = 1'b1;
            a_ie   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_oe = 1'b1;
            b_ie   = 1'b1;
          end
          default: ;
        endcase
        T6: if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_oe  = 1'b1;
          a_ie    = 1'b1;
          alu_sub = (opcode == OP_SUB);
        end
        default: ;
      endcase
    end
  end

  assign state_bits = state_q;
  assign t_state    = state_bits[5:0];
  assign halted     = state_bits[6];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector table plus hand sequences and a randomized invariant sweep
// for control_sequencer.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, run;
  logic [3:0] opcode;
  logic       pc_inc, pc_oe, pc_ld, mar_ie, ram_oe, ir_ie, ir_oe;
  logic       a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie, halted;
  logic [5:0] t_state;

  control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .pc_inc(pc_inc), .pc_oe(pc_oe), .pc_ld(pc_ld), .mar_ie(mar_ie),
    .ram_oe(ram_oe), .ir_ie(ir_ie), .ir_oe(ir_oe), .a_ie(a_ie),
    .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .out_ie(out_ie), .halted(halted), .t_state(t_state)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] PC_INC  = 13'h1000;
  localparam logic [12:0] PC_OE   = 13'h0800;
  localparam logic [12:0] PC_LD   = 13'h0400;
  localparam logic [12:0] MAR_IE  = 13'h0200;
  localparam logic [12:0] RAM_OE  = 13'h0100;
  localparam logic [12:0] IR_IE   = 13'h0080;
  localparam logic [12:0] IR_OE   = 13'h0040;
  localparam logic [12:0] A_IE    = 13'h0020;
  localparam logic [12:0] A_OE    = 13'h0010;
  localparam logic [12:0] B_IE    = 13'h0008;
  localparam logic [12:0] ALU_OE  = 13'h0004;
  localparam logic [12:0] ALU_SUB = 13'h0002;
  localparam logic [12:0] OUT_IE  = 13'h0001;
  localparam logic [12:0] F1 = PC_OE | MAR_IE;
  localparam logic [12:0] F2 = PC_INC;
  localparam logic [12:0] F3 = RAM_OE | IR_IE;
  localparam logic [5:0] S1 = 6'h01, S2 = 6'h02, S3 = 6'h04;
  localparam logic [5:0] S4 = 6'h08, S5 = 6'h10, S6 = 6'h20, SH = 6'h00;

  logic [12:0] ctrl;
  assign ctrl = {pc_inc, pc_oe, pc_ld, mar_ie, ram_oe, ir_ie, ir_oe,
                 a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie};

  typedef struct {
    logic        rst;
    logic        run;
    logic [3:0]  op;
    logic [5:0]  t;
    logic [12:0] ctrl;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic r, input logic rn, input logic [3:0] op,
                     input logic [5:0] t, input logic [12:0] c, input logic h);
    vec_t v;
    v.rst = r; v.run = rn; v.op = op; v.t = t; v.ctrl = c; v.halted = h;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 4'h0;

    add(1, 1, 4'h0, S1, 13'h0, 0);
    // LDA
    add(0, 1, 4'h0, S1, F1, 0);
    add(0, 1, 4'h0, S2, F2, 0);
    add(0, 1, 4'h0, S3, F3, 0);
    add(0, 1, 4'h0, S4, IR_OE | MAR_IE, 0);
    add(0, 1, 4'h0, S5, RAM_OE | A_IE, 0);
    add(0, 1, 4'h0, S6, 13'h0, 0);
    // ADD
    add(0, 1, 4'h1, S1, F1, 0);
    add(0, 1, 4'h1, S2, F2, 0);
    add(0, 1, 4'h1, S3, F3, 0);
    add(0, 1, 4'h1, S4, IR_OE | MAR_IE, 0);
    add(0, 1, 4'h1, S5, RAM_OE | B_IE, 0);
    add(0, 1, 4'h1, S6, ALU_OE | A_IE, 0);
    // SUB, with a different opcode presented during fetch
    add(0, 1, 4'h9, S1, F1, 0);
    add(0, 1, 4'h6, S2, F2, 0);
    add(0, 1, 4'hF, S3, F3, 0);
    add(0, 1, 4'h2, S4, IR_OE | MAR_IE, 0);
    add(0, 1, 4'h2, S5, RAM_OE | B_IE, 0);
    add(0, 1, 4'h2, S6, ALU_OE | A_IE | ALU_SUB, 0);
    // JMP
    add(0, 1, 4'h6, S1, F1, 0);
    add(0, 1, 4'h6, S2, F2, 0);
    add(0, 1, 4'h6, S3, F3, 0);
    add(0, 1, 4'h6, S4, IR_OE | PC_LD, 0);
    add(0, 1, 4'h6, S5, 13'h0, 0);
    add(0, 1, 4'h6, S6, 13'h0, 0);
    // OUT
    add(0, 1, 4'hE, S1, F1, 0);
    add(0, 1, 4'hE, S2, F2, 0);
    add(0, 1, 4'hE, S3, F3, 0);
    add(0, 1, 4'hE, S4, A_OE | OUT_IE, 0);
    add(0, 1, 4'hE, S5, 13'h0, 0);
    add(0, 1, 4'hE, S6, 13'h0, 0);
    // Unmapped 0x7; run drops in T4 and the machine parks at T1
    add(0, 1, 4'h7, S1, F1, 0);
    add(0, 1, 4'h7, S2, F2, 0);
    add(0, 1, 4'h7, S3, F3, 0);
    add(0, 0, 4'h7, S4, 13'h0, 0);
    add(0, 0, 4'h7, S5, 13'h0, 0);
    add(0, 0, 4'h7, S6, 13'h0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 4'h1, S1, 13'h0, 0);
    // Resume with ADD, aborted by rst in T5
    add(0, 1, 4'h1, S1, F1, 0);
    add(0, 1, 4'h1, S2, F2, 0);
    add(0, 1, 4'h1, S3, F3, 0);
    add(0, 1, 4'h1, S4, IR_OE | MAR_IE, 0);
    add(1, 1, 4'h1, S5, 13'h0, 0);
    // HLT
    add(0, 1, 4'hF, S1, F1, 0);
    add(0, 1, 4'hF, S2, F2, 0);
    add(0, 1, 4'hF, S3, F3, 0);
    add(0, 1, 4'hF, S4, 13'h0, 0);
    add(0, 1, 4'hF, SH, 13'h0, 1);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; run = vecs[i].run; opcode = vecs[i].op;
      #1;
      chk($sformatf("vec%0d t_state", i), 32'(t_state), 32'(vecs[i].t));
      chk($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].halted));
    end

    // HALT holds regardless of run and opcode
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run = i[0]; opcode = 4'(i);
      #1;
      chk($sformatf("halt%0d", i), {17'h0, halted, t_state, ctrl}, {17'h0, 1'b1, 6'h00, 13'h0});
    end

    // One-cycle reset pulse leaves HALT into T1
    @(negedge clk); rst = 1'b1; run = 1'b1; opcode = 4'h0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_exit", {17'h0, halted, t_state, ctrl}, {17'h0, 1'b0, S1, F1});
    @(negedge clk);
    #1;
    chk("rst_exit_t2", {17'h0, halted, t_state, ctrl}, {17'h0, 1'b0, S2, F2});

    // Random sweep: bus-driver exclusivity, fetch strobes, silent unmapped opcodes
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst = halted;
      run = 1'($urandom);
      opcode = 4'($urandom);
      #1;
      chk("bus_onehot", 32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1), 32'd1);
      if (rst) chk("rst_quiet", 32'(ctrl), 32'h0);
      else if (t_state == S1) chk("rand_t1", 32'(ctrl), run ? 32'(F1) : 32'h0);
      else if (t_state == S2) chk("rand_t2", 32'(ctrl), 32'(F2));
      else if (t_state == S3) chk("rand_t3", 32'(ctrl), 32'(F3));
      else if (t_state inside {S4, S5, S6} &&
               !(opcode inside {4'h0, 4'h1, 4'h2, 4'h6, 4'hE}))
        chk("rand_nop", 32'(ctrl), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
